// File: rtl/rle_pkg.sv
// rle_pkg: shared types and helpers for the zero-run-length coder.
package rle_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        EMIT_Z,
        EMIT_D,
        FLUSH,
        DONE
    } state_t;

    localparam byte_t DIGIT_BASE = 8'h30;

    function automatic int dec_digits(input int v);
        int n;
        int t;
        n = 1;
        t = v;
        for (int i = 0; i < 9; i++) begin
            if (t >= 10) begin
                t = t / 10;
                n++;
            end
        end
        return n;
    endfunction

    localparam int RUN_DIGITS = dec_digits(99);

    function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hffff_ffff : s[31:0];
    endfunction

endpackage

// File: rtl/rle_bcd_run_counter.sv
// rle_bcd_run_counter: BCD run length with digit select and
// most-significant-nonzero digit index for decimal token emission.
module rle_bcd_run_counter
    import rle_pkg::*;
#(
    parameter int DIGITS  = RUN_DIGITS,
    parameter int MAX_RUN = 99,
    parameter int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk_source,
    input  logic          rst_source,
    input  logic          inc,
    input  logic          clr,
    input  logic [DW-1:0] sel,
    output logic [3:0]    digit,
    output logic [DW-1:0] msb_idx,
    output logic          nonzero,
    output logic          at_cap
);

    localparam int BW = $clog2(MAX_RUN + 1);

    logic [DIGITS-1:0][3:0] dig;
    logic [DIGITS-1:0][3:0] dig_n;
    logic [BW-1:0]          bin;
    logic                   carry;

    always_comb begin
        dig_n = dig;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (dig[i] == 4'd9) begin
                    dig_n[i] = 4'd0;
                end else begin
                    dig_n[i] = dig[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
    end

    always_comb begin
        msb_idx = '0;
        digit   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig[i] != 4'd0) msb_idx = DW'(i);
            if (DW'(i) == sel) digit = dig[i];
        end
    end

    assign nonzero = |dig;
    // Binary shadow makes the cap test a single compare.
    assign at_cap  = (bin == BW'(MAX_RUN - 1));

    always_ff @(posedge clk_source) begin
        if (rst_source || clr) begin
            dig <= '0;
            bin <= '0;
        end else if (inc) begin
            dig <= dig_n;
            bin <= bin + BW'(1);
        end
    end

endmodule

// File: rtl/rle_zero_coder_param.sv
// rle_zero_coder_param: streaming zero-run-length coder with word repacking.
// Define RLE_CODER_STATS_EN to add input/output byte statistics ports.
module rle_zero_coder_param
    import rle_pkg::*;
#(
    parameter int    N_BYTES   = 4,
    parameter byte_t ZERO_CHAR = 8'h30,
    parameter int    MAX_RUN   = 99
) (
    input  logic                         clk_source,
    input  logic                         rst_source,
    input  logic                         start_source,
    input  logic                         in_valid_source,
    input  logic                         last_source,
    input  logic [N_BYTES-1:0][7:0]      input_data_source,
    output logic                         in_ready_port,
    input  logic                         read_success,
    output logic                         result_ready_port,
    output logic [N_BYTES-1:0][7:0]      coded_data_port,
    output logic [$clog2(N_BYTES+1)-1:0] coded_bytes_port,
    output logic                         finish_port
`ifdef RLE_CODER_STATS_EN
    ,
    output logic [31:0]                  stat_in_bytes_port,
    output logic [31:0]                  stat_out_bytes_port
`endif
);

    localparam int FW     = $clog2(N_BYTES + 1);
    localparam int SW     = $clog2(N_BYTES);
    localparam int DIGITS = dec_digits(MAX_RUN);
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                 state, state_n;
    logic [FW-1:0]          idx, idx_n;
    logic [FW-1:0]          fill;
    logic [DW-1:0]          dptr, dptr_n;
    logic [N_BYTES-1:0][7:0] word_q;
    logic                   last_q;
    logic                   load, push, read, full, raise;
    logic                   run_inc, run_clr;
    byte_t                  push_byte, cur;
    logic [3:0]             digit;
    logic [DW-1:0]          msb_idx;
    logic                   run_nz, run_hit, word_end;

    rle_bcd_run_counter #(
        .DIGITS  (DIGITS),
        .MAX_RUN (MAX_RUN),
        .DW      (DW)
    ) u_run (
        .clk_source (clk_source),
        .rst_source (rst_source),
        .inc        (run_inc),
        .clr        (run_clr),
        .sel        (dptr),
        .digit      (digit),
        .msb_idx    (msb_idx),
        .nonzero    (run_nz),
        .at_cap     (run_hit)
    );

    assign in_ready_port = (state == LOAD);
    assign full          = (fill == FW'(N_BYTES));
    assign read          = read_success && result_ready_port;
    assign cur           = word_q[idx[SW-1:0]];
    assign word_end      = (idx == FW'(N_BYTES - 1));
    // Partial words are only presented once the frame is fully coded.
    assign raise         = !result_ready_port &&
                           (full || (state == FLUSH && fill != '0));

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        dptr_n    = dptr;
        load      = 1'b0;
        push      = 1'b0;
        push_byte = '0;
        run_inc   = 1'b0;
        run_clr   = 1'b0;
        unique case (state)
            IDLE: if (start_source) state_n = LOAD;
            LOAD: begin
                if (in_valid_source) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (!full) begin
                    if (cur == ZERO_CHAR) begin
                        run_inc = 1'b1;
                        idx_n   = idx + FW'(1);
                        if (run_hit)       state_n = EMIT_Z;
                        else if (word_end) state_n = last_q ? EMIT_Z : LOAD;
                    end else if (run_nz) begin
                        state_n = EMIT_Z;
                    end else begin
                        push      = 1'b1;
                        push_byte = cur;
                        idx_n     = idx + FW'(1);
                        if (word_end) state_n = last_q ? FLUSH : LOAD;
                    end
                end
            end
            EMIT_Z: begin
                if (!full) begin
                    push      = 1'b1;
                    push_byte = ZERO_CHAR;
                    dptr_n    = msb_idx;
                    state_n   = EMIT_D;
                end
            end
            EMIT_D: begin
                if (!full) begin
                    push      = 1'b1;
                    push_byte = DIGIT_BASE + {4'h0, digit};
                    if (dptr == '0) begin
                        run_clr = 1'b1;
                        if (idx == FW'(N_BYTES)) state_n = last_q ? FLUSH : LOAD;
                        else                     state_n = SCAN;
                    end else begin
                        dptr_n = dptr - DW'(1);
                    end
                end
            end
            FLUSH: begin
                if (result_ready_port) begin
                    if (read_success) state_n = DONE;
                end else if (fill == '0) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_source) begin
        if (rst_source) begin
            state             <= IDLE;
            idx               <= '0;
            dptr              <= '0;
            word_q            <= '0;
            last_q            <= 1'b0;
            fill              <= '0;
            coded_data_port   <= '0;
            coded_bytes_port  <= '0;
            result_ready_port <= 1'b0;
            finish_port       <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dptr        <= dptr_n;
            finish_port <= (state_n == DONE);
            if (load) begin
                word_q <= input_data_source;
                last_q <= last_source;
            end
            if (read) begin
                result_ready_port <= 1'b0;
                fill              <= '0;
                coded_data_port   <= '0;
                coded_bytes_port  <= '0;
            end else begin
                if (push) begin
                    coded_data_port[fill[SW-1:0]] <= push_byte;
                    fill                          <= fill + FW'(1);
                end
                if (raise) begin
                    result_ready_port <= 1'b1;
                    coded_bytes_port  <= fill;
                end
            end
        end
    end

`ifdef RLE_CODER_STATS_EN
    always_ff @(posedge clk_source) begin
        if (rst_source || (state == IDLE && start_source)) begin
            stat_in_bytes_port  <= '0;
            stat_out_bytes_port <= '0;
        end else begin
            if (load)
                stat_in_bytes_port <= sat_add32(stat_in_bytes_port, 32'(N_BYTES));
            if (read)
                stat_out_bytes_port <= sat_add32(stat_out_bytes_port,
                                                 32'(coded_bytes_port));
        end
    end
`endif

endmodule

// File: tb/tb_rle_zero_coder_param.sv
// tb_rle_zero_coder_param: scoreboard bench, unit 0 with MAX_RUN=9 and
// unit 1 with MAX_RUN=99; stats checks when RLE_CODER_STATS_EN is defined.
module tb_rle_zero_coder_param;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        vld   [2];
    logic        last  [2];
    logic        rd    [2];
    logic        rdy_in[2];
    logic        rdy   [2];
    logic        fin   [2];
    logic        hold  [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic [2:0]  cb    [2];
`ifdef RLE_CODER_STATS_EN
    logic [31:0] st_in [2];
    logic [31:0] st_out[2];
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   fin_cnt[2] = '{0, 0};
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rle_zero_coder_param #(.N_BYTES(4), .ZERO_CHAR(8'h30), .MAX_RUN(9)) dut0 (
        .clk_source        (clk),
        .rst_source        (rst),
        .start_source      (start[0]),
        .in_valid_source   (vld[0]),
        .last_source       (last[0]),
        .input_data_source (din[0]),
        .in_ready_port     (rdy_in[0]),
        .read_success      (rd[0]),
        .result_ready_port (rdy[0]),
        .coded_data_port   (dout[0]),
        .coded_bytes_port  (cb[0]),
        .finish_port       (fin[0])
`ifdef RLE_CODER_STATS_EN
        ,
        .stat_in_bytes_port  (st_in[0]),
        .stat_out_bytes_port (st_out[0])
`endif
    );

    rle_zero_coder_param #(.N_BYTES(4), .ZERO_CHAR(8'h30), .MAX_RUN(99)) dut1 (
        .clk_source        (clk),
        .rst_source        (rst),
        .start_source      (start[1]),
        .in_valid_source   (vld[1]),
        .last_source       (last[1]),
        .input_data_source (din[1]),
        .in_ready_port     (rdy_in[1]),
        .read_success      (rd[1]),
        .result_ready_port (rdy[1]),
        .coded_data_port   (dout[1]),
        .coded_bytes_port  (cb[1]),
        .finish_port       (fin[1])
`ifdef RLE_CODER_STATS_EN
        ,
        .stat_in_bytes_port  (st_in[1]),
        .stat_out_bytes_port (st_out[1])
`endif
    );

    function automatic logic [31:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input int u, input logic [31:0] d, input logic [2:0] b);
        exp_t e;
        e.d = d;
        e.b = b;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a unit presents a word.
    initial begin
        exp_t e;
        rd[0] = 1'b0;
        rd[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                rd[u] = 1'b0;
                if (fin[u]) fin_cnt[u]++;
                if (rdy[u] && !hold[u]) begin
                    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected word u%0d: got %0h/%0d want none",
                                 u, dout[u], cb[u]);
                    end else begin
                        if (u == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("word data u%0d", u), dout[u], e.d);
                        chk($sformatf("word bytes u%0d", u), 32'(cb[u]), 32'(e.b));
                    end
                    rd[u] = 1'b1;
                end
            end
        end
    end

    task automatic open_frame(input int u);
        int k;
        k = 0;
        start[u] = 1'b1;
        while (!rdy_in[u] && k < 50) begin
            @(negedge clk);
            k++;
        end
        start[u] = 1'b0;
        if (!rdy_in[u]) begin
            n_cmp++;
            n_err++;
            $display("FAIL open u%0d: got in_ready 0 want 1", u);
        end
    endtask

    task automatic send(input int u, input logic [31:0] d, input logic l);
        int k;
        k = 0;
        vld[u]  = 1'b1;
        din[u]  = d;
        last[u] = l;
        while (!rdy_in[u] && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!rdy_in[u]) begin
            n_cmp++;
            n_err++;
            $display("FAIL send timeout u%0d: got in_ready 0 want 1", u);
        end
        @(negedge clk);
        vld[u] = 1'b0;
    endtask

    task automatic wait_rdy(input int u);
        int k;
        k = 0;
        while (!rdy[u] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("result_ready u%0d", u), 32'(rdy[u]), 32'd1);
    endtask

    task automatic wait_fin(input int u, input int target);
        int k;
        k = 0;
        while (fin_cnt[u] < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("finish count u%0d", u), fin_cnt[u], target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            vld[u]   = 1'b0;
            last[u]  = 1'b0;
            din[u]   = '0;
            hold[u]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset result_ready", 32'(rdy[0]), 32'd0);
        chk("reset data", dout[0], 32'd0);
        chk("reset bytes", 32'(cb[0]), 32'd0);
        chk("reset finish", 32'(fin[0]), 32'd0);
        chk("reset in_ready", 32'(rdy_in[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Plain word, no zeros
        open_frame(0);
        expect_word(0, pk("A", "B", "C", "D"), 3'd4);
        send(0, pk("A", "B", "C", "D"), 1'b1);
        wait_fin(0, 1);

        // Run spanning words, partial final word
        open_frame(0);
        expect_word(0, pk("A", "0", "7", "B"), 3'd4);
        expect_word(0, pk("C", "D", "E", 8'h00), 3'd3);
        send(0, pk("A", "0", "0", "0"), 1'b0);
        send(0, pk("0", "0", "0", "0"), 1'b0);
        send(0, pk("B", "C", "D", "E"), 1'b1);
        wait_fin(0, 2);
`ifdef RLE_CODER_STATS_EN
        chk("stat_in u0", st_in[0], 32'd12);
        chk("stat_out u0", st_out[0], 32'd7);
`endif

        // Run cap split at 9, then multi-digit token at cap 99
        open_frame(0);
        expect_word(0, pk("0", "9", "0", "3"), 3'd4);
        expect_word(0, pk("X", "Y", "Z", "W"), 3'd4);
        for (int i = 0; i < 3; i++) send(0, pk("0", "0", "0", "0"), 1'b0);
        send(0, pk("X", "Y", "Z", "W"), 1'b1);
        wait_fin(0, 3);

        open_frame(1);
        expect_word(1, pk("0", "1", "2", "X"), 3'd4);
        expect_word(1, pk("Y", "Z", "W", 8'h00), 3'd3);
        for (int i = 0; i < 3; i++) send(1, pk("0", "0", "0", "0"), 1'b0);
        send(1, pk("X", "Y", "Z", "W"), 1'b1);
        wait_fin(1, 1);
`ifdef RLE_CODER_STATS_EN
        chk("stat_in u1", st_in[1], 32'd16);
        chk("stat_out u1", st_out[1], 32'd7);
`endif

        // Back-pressure: hold the full word for 10 cycles
        hold[0] = 1'b1;
        open_frame(0);
        expect_word(0, pk("A", "B", "C", "D"), 3'd4);
        expect_word(0, pk("E", "F", "G", "H"), 3'd4);
        expect_word(0, pk("I", "J", "0", "2"), 3'd4);
        send(0, pk("A", "B", "C", "D"), 1'b0);
        send(0, pk("E", "F", "G", "H"), 1'b0);
        wait_rdy(0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dout[0] !== pk("A", "B", "C", "D") || rdy[0] !== 1'b1 || rdy_in[0] !== 1'b0)
                bad++;
        end
        chk("hold unstable cycles", bad, 0);
        chk("hold in_ready", 32'(rdy_in[0]), 32'd0);
        hold[0] = 1'b0;
        send(0, pk("I", "J", "0", "0"), 1'b1);
        wait_fin(0, 4);

        // Reset mid-frame discards buffered word, no finish pulse
        hold[0] = 1'b1;
        open_frame(0);
        send(0, pk("A", "B", "C", "D"), 1'b0);
        wait_rdy(0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset result_ready", 32'(rdy[0]), 32'd0);
        chk("midreset data", dout[0], 32'd0);
        chk("midreset bytes", 32'(cb[0]), 32'd0);
        chk("midreset in_ready", 32'(rdy_in[0]), 32'd0);
        chk("midreset finish", 32'(fin[0]), 32'd0);
        rst = 1'b0;
        hold[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("no finish after reset", fin_cnt[0], 4);
        open_frame(0);
        expect_word(0, pk("0", "1", "B", "0"), 3'd4);
        expect_word(0, pk("2", 8'h00, 8'h00, 8'h00), 3'd1);
        send(0, pk("0", "B", "0", "0"), 1'b1);
        wait_fin(0, 5);

        repeat (5) @(negedge clk);
        chk("scoreboard u0 drained", 32'(q0.size()), 32'd0);
        chk("scoreboard u1 drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
